// File: rtl/main_decoder_if.sv
// Opcode-in / control-out bundle for the main instruction decoder.
// Latency: none (wires only); the decoder behind it registers everything.
// Backpressure: none; op is consumed every cycle.
interface main_decoder_if;
    logic [6:0] op;
    logic       branch;
    logic       jump;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] imm_src;
    logic [1:0] alu_op;

    // Fetch side drives op and consumes the control word
    modport master (
        output op,
        input  branch, jump, mem_write, alu_src, reg_write,
        input  result_src, imm_src, alu_op
    );

    // Decoder side consumes op and drives the control word
    modport slave (
        input  op,
        output branch, jump, mem_write, alu_src, reg_write,
        output result_src, imm_src, alu_op
    );
endinterface

// File: rtl/main_decoder.sv
// Main control decoder: maps the 7-bit opcode to datapath control signals.
// Latency: exactly one clk; outputs are registered and held between edges.
// Backpressure: none; a new op is sampled every cycle, unknown ops decode to a NOP.
module main_decoder (
    input  logic           clk,
    input  logic           rst_n,
    main_decoder_if.slave  dec
);

    typedef struct packed {
        logic       reg_write;
        logic [1:0] imm_src;
        logic       alu_src;
        logic       mem_write;
        logic [1:0] result_src;
        logic       branch;
        logic [1:0] alu_op;
        logic       jump;
    } ctrl_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_IALU  = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    ctrl_t ctrl_nxt;
    ctrl_t ctrl_q;

    // Combinational decode; anything not in the table (including X) stays all-zero
    always_comb begin
        ctrl_nxt = '0;
        case (dec.op)
            OP_LW: begin
                ctrl_nxt.reg_write  = 1'b1;
                ctrl_nxt.alu_src    = 1'b1;
                ctrl_nxt.result_src = 2'b01;
            end
            OP_SW: begin
                ctrl_nxt.imm_src    = 2'b01;
                ctrl_nxt.alu_src    = 1'b1;
                ctrl_nxt.mem_write  = 1'b1;
            end
            OP_RTYPE: begin
                ctrl_nxt.reg_write  = 1'b1;
                ctrl_nxt.alu_op     = 2'b10;
            end
            OP_IALU: begin
                ctrl_nxt.reg_write  = 1'b1;
                ctrl_nxt.alu_src    = 1'b1;
                ctrl_nxt.alu_op     = 2'b10;
            end
            OP_BEQ: begin
                ctrl_nxt.imm_src    = 2'b10;
                ctrl_nxt.branch     = 1'b1;
                ctrl_nxt.alu_op     = 2'b01;
            end
            OP_JAL: begin
                ctrl_nxt.reg_write  = 1'b1;
                ctrl_nxt.imm_src    = 2'b11;
                ctrl_nxt.result_src = 2'b10;
                ctrl_nxt.jump       = 1'b1;
            end
            OP_JALR: begin
                ctrl_nxt.reg_write  = 1'b1;
                ctrl_nxt.alu_src    = 1'b1;
                ctrl_nxt.result_src = 2'b10;
                ctrl_nxt.jump       = 1'b1;
            end
            default: ctrl_nxt = '0;
        endcase
    end

    // Output register; reset wins over decode and discards the in-flight result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_q <= '0;
        end else begin
            ctrl_q <= ctrl_nxt;
        end
    end

    assign dec.reg_write  = ctrl_q.reg_write;
    assign dec.imm_src    = ctrl_q.imm_src;
    assign dec.alu_src    = ctrl_q.alu_src;
    assign dec.mem_write  = ctrl_q.mem_write;
    assign dec.result_src = ctrl_q.result_src;
    assign dec.branch     = ctrl_q.branch;
    assign dec.alu_op     = ctrl_q.alu_op;
    assign dec.jump       = ctrl_q.jump;

endmodule

// File: tb/tb_main_decoder.sv
// Bench for main_decoder: directed table cases plus randomized op/reset stream.
// Expected control word comes from the instruction table below, one edge late.
// No backpressure on the DUT; op and rst_n are driven every cycle.
module tb_main_decoder;

    logic clk;
    logic rst_n;
    main_decoder_if dec_if ();

    main_decoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .dec   (dec_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;

    // Instruction table: opcode and the control word
    // {reg_write, imm_src, alu_src, mem_write, result_src, branch, alu_op, jump}
    localparam int NOPS = 7;
    logic [6:0]  tbl_op   [NOPS];
    logic [10:0] tbl_ctrl [NOPS];

    initial begin
        tbl_op[0] = 7'b0000011; tbl_ctrl[0] = 11'b1_00_1_0_01_0_00_0; // lw
        tbl_op[1] = 7'b0100011; tbl_ctrl[1] = 11'b0_01_1_1_00_0_00_0; // sw
        tbl_op[2] = 7'b0110011; tbl_ctrl[2] = 11'b1_00_0_0_00_0_10_0; // R-type
        tbl_op[3] = 7'b0010011; tbl_ctrl[3] = 11'b1_00_1_0_00_0_10_0; // I-type ALU
        tbl_op[4] = 7'b1100011; tbl_ctrl[4] = 11'b0_10_0_0_00_1_01_0; // beq
        tbl_op[5] = 7'b1101111; tbl_ctrl[5] = 11'b1_11_0_0_10_0_00_1; // jal
        tbl_op[6] = 7'b1100111; tbl_ctrl[6] = 11'b1_00_1_0_10_0_00_1; // jalr
    end

    function automatic logic [10:0] ref_ctrl(input logic [6:0] op, input logic rst);
        logic [10:0] r;
        r = '0;
        if (rst) begin
            for (int i = 0; i < NOPS; i++)
                if (tbl_op[i] == op) r = tbl_ctrl[i];
        end
        return r;
    endfunction

    function automatic logic [10:0] observed();
        return {dec_if.reg_write, dec_if.imm_src, dec_if.alu_src, dec_if.mem_write,
                dec_if.result_src, dec_if.branch, dec_if.alu_op, dec_if.jump};
    endfunction

    task automatic check(input string tag, input logic [10:0] got, input logic [10:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Apply op/rst_n, take one rising edge, then compare just after it
    task automatic step(input string tag, input logic [6:0] op, input logic rst);
        logic [10:0] exp;
        dec_if.op = op;
        rst_n     = rst;
        exp       = ref_ctrl(op, rst);
        @(posedge clk);
        #1;
        check(tag, observed(), exp);
        check({tag, "_br_jmp"}, {10'b0, dec_if.branch & dec_if.jump}, 11'b0);
        check({tag, "_mw_rw"},  {10'b0, dec_if.mem_write & dec_if.reg_write}, 11'b0);
    endtask

    logic [10:0] held;

    initial begin
        total = 0;
        bad   = 0;
        dec_if.op = 7'b0000011;
        rst_n     = 1'b0;
        @(negedge clk);

        // Reset held for two edges with lw on op, then release
        step("rst0", 7'b0000011, 1'b0);
        check("rst0_abs", observed(), 11'b0);
        step("rst1", 7'b0000011, 1'b0);
        step("lw_after_rst", 7'b0000011, 1'b1);
        check("lw_abs", observed(), 11'b1_00_1_0_01_0_00_0);

        // Back-to-back different opcodes
        step("sw",    7'b0100011, 1'b1);
        check("sw_abs", observed(), 11'b0_01_1_1_00_0_00_0);
        step("rtype", 7'b0110011, 1'b1);
        step("beq",   7'b1100011, 1'b1);
        check("beq_abs", observed(), 11'b0_10_0_0_00_1_01_0);
        step("jal",   7'b1101111, 1'b1);
        check("jal_abs", observed(), 11'b1_11_0_0_10_0_00_1);
        step("jalr",  7'b1100111, 1'b1);
        check("jalr_abs", observed(), 11'b1_00_1_0_10_0_00_1);

        // Unknown opcodes decode to NOP
        step("op_zero", 7'b0000000, 1'b1);
        step("op_05",   7'b0000101, 1'b1);
        step("op_ones", 7'b1111111, 1'b1);
        check("op_ones_abs", observed(), 11'b0);

        // Mid-stream single-edge reset during steady R-type
        step("r_steady0", 7'b0110011, 1'b1);
        step("r_steady1", 7'b0110011, 1'b1);
        check("r_same", observed(), 11'b1_00_0_0_00_0_10_0);
        step("r_rst",     7'b0110011, 1'b0);
        step("r_resume",  7'b0110011, 1'b1);

        // I-type, then disturb op and rst_n between edges: outputs must hold
        step("ialu", 7'b0010011, 1'b1);
        check("ialu_abs", observed(), 11'b1_00_1_0_00_0_10_0);
        held = observed();
        dec_if.op = 7'b1101111;
        #1;
        rst_n = 1'b0;
        #1;
        check("hold_op_chg", observed(), 11'b1_00_1_0_00_0_10_0);
        rst_n = 1'b1;
        #1;
        check("hold_rst_glitch", observed(), held);
        step("after_glitch", 7'b1101111, 1'b1);

        // Randomized stream: mostly table opcodes, some arbitrary ones, rare resets
        for (int n = 0; n < 400; n++) begin
            logic [6:0] op;
            logic       rst;
            if ($urandom_range(0, 3) != 0)
                op = tbl_op[$urandom_range(0, NOPS - 1)];
            else
                op = 7'($urandom);
            rst = ($urandom_range(0, 15) != 0);
            step("rand", op, rst);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Guard against a stalled run
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
